// File: rtl/fifo_pkg.sv
// Shared constants and types for fifo_stream_reader and its output buffer.
package fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned OCC_W         = 2;
  localparam int unsigned BEAT_W        = 8;
  localparam int unsigned WORD_CNT_W    = 16;
  localparam int unsigned BUF_DEPTH     = 2;

  typedef logic [OCC_W-1:0]  occ_t;
  typedef logic [BEAT_W-1:0] beat_cnt_t;

  // Beat index within a burst, wrapping after last_idx.
  function automatic beat_cnt_t next_beat(input beat_cnt_t cnt, input beat_cnt_t last_idx);
    return (cnt >= last_idx) ? '0 : beat_cnt_t'(cnt + 8'd1);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order output buffer; simultaneous push and pop retire the head
// and append the new word in the same edge.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output occ_t             o_occ,
  output logic [WIDTH-1:0] o_data
);

  localparam occ_t FULL = occ_t'(BUF_DEPTH);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  occ_t             occ_q, occ_d;
  logic             push_ok;
  logic             pop_ok;

  // Next-state: head is always the oldest word, tail the younger one.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    pop_ok  = i_pop && (occ_q != '0);
    push_ok = i_push && ((occ_q != FULL) || pop_ok);
    case ({push_ok, pop_ok})
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = i_push_data;
        end else begin
          head_d = tail_q;
          tail_d = i_push_data;
        end
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == '0) begin
          head_d = i_push_data;
        end else begin
          tail_d = i_push_data;
        end
        occ_d = occ_q + 2'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign o_occ  = occ_q;
  assign o_data = head_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pulls words from a 1-cycle-latency FIFO into a credit-limited output stream
// with burst framing. Define FIFO_STREAM_READER_STATS_EN to add o_word_count.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  input  logic [WIDTH-1:0]      i_fifo_rd_data,
  output logic                  o_fifo_rd_en,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_last
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [WORD_CNT_W-1:0] o_word_count
`endif
);

  localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(BURST_LEN - 1);

  occ_t       occ;
  logic       in_flight_q, in_flight_d;
  beat_cnt_t  beat_q, beat_d;
  logic       accept;
  logic       rd_issue;
  logic [2:0] credit;

  fifo_skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid_buf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (in_flight_q),
    .i_push_data (i_fifo_rd_data),
    .i_pop       (accept),
    .o_occ       (occ),
    .o_data      (o_data)
  );

  assign o_valid = (occ != '0);
  assign accept  = o_valid & i_ready;

  // Words held plus words landing, less the one leaving this cycle.
  assign credit   = 3'(occ) + 3'(in_flight_q) - 3'(accept);
  assign rd_issue = ~i_rst & i_enable & ~i_fifo_empty & (credit < 3'd2);

  assign o_fifo_rd_en = rd_issue;
  assign o_last       = o_valid & (beat_q == LAST_BEAT);

  always_comb begin
    in_flight_d = rd_issue;
    beat_d      = beat_q;
    if (accept) begin
      beat_d = next_beat(beat_q, LAST_BEAT);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      in_flight_q <= 1'b0;
      beat_q      <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      beat_q      <= beat_d;
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (accept) begin
      word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign o_word_count = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and randomized bench for fifo_stream_reader against a queue-based
// model of the FIFO and the delivered stream.
module tb_fifo_stream_reader;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned BURST_LEN = 4;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             fifo_empty;
  logic [WIDTH-1:0] rd_data;
  logic             rd_en;
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             last;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [15:0]      word_count;
`endif

  fifo_stream_reader #(
    .WIDTH     (WIDTH),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (enable),
    .i_fifo_empty   (fifo_empty),
    .i_fifo_rd_data (rd_data),
    .o_fifo_rd_en   (rd_en),
    .o_valid        (valid),
    .i_ready        (ready),
    .o_data         (data),
    .o_last         (last)
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    .o_word_count   (word_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks;
  int          errors;
  int unsigned src_q[$];
  int unsigned exp_q[$];
  int unsigned sent_q[$];
  bit          in_flight;
  int unsigned beats;
  int unsigned total_beats;
  bit          force_empty;
  int          cyc;
  int          rd_cnt;
  int          first_rd;
  int          first_valid;
  int unsigned got_q[$];
  bit          last_q[$];
  int          pop_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_empty();
    fifo_empty = force_empty || (src_q.size() == 0);
  endtask

  task automatic clr_track();
    rd_cnt      = 0;
    first_rd    = -1;
    first_valid = -1;
    got_q.delete();
    last_q.delete();
    pop_cyc.delete();
  endtask

  task automatic load(input int unsigned w);
    src_q.push_back(w);
    sent_q.push_back(w);
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic do_cycle();
    int          occ;
    bit          exp_valid, exp_pop, exp_rd, exp_last, was_rst;
    int unsigned w;
    w = 0;
    #1;
    occ       = int'(exp_q.size()) - int'(in_flight);
    exp_valid = (occ > 0);
    exp_pop   = exp_valid && ready;
    exp_rd    = !rst && enable && !fifo_empty && ((occ + int'(in_flight) - int'(exp_pop)) < 2);
    exp_last  = exp_valid && ((beats % BURST_LEN) == BURST_LEN - 1);
    chk("rd_en", 32'(rd_en), 32'(exp_rd));
    chk("valid", 32'(valid), 32'(exp_valid));
    chk("last", 32'(last), 32'(exp_last));
    if (exp_valid) chk("data", 32'(data), exp_q[0]);
    if (exp_rd) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (exp_valid && first_valid < 0) first_valid = cyc;
    if (exp_pop) begin
      got_q.push_back(32'(data));
      last_q.push_back(last);
      pop_cyc.push_back(cyc);
    end
    was_rst = rst;
    @(posedge clk);
    if (was_rst) begin
      exp_q.delete();
      in_flight   = 1'b0;
      beats       = 0;
      total_beats = 0;
    end else begin
      if (exp_pop) begin
        void'(exp_q.pop_front());
        beats++;
        total_beats++;
      end
      in_flight = exp_rd;
      if (exp_rd) begin
        w = src_q.pop_front();
        exp_q.push_back(w);
      end
    end
    @(negedge clk);
    cyc++;
    rd_data = exp_rd ? WIDTH'(w) : WIDTH'($urandom);
    set_empty();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    in_flight = 0; beats = 0; total_beats = 0; force_empty = 0;
    rst = 1'b1; enable = 1'b0; ready = 1'b0; fifo_empty = 1'b1; rd_data = '0;
    clr_track();
    repeat (2) @(negedge clk);

    // Reset holds reads off even with data available.
    for (int i = 0; i < 8; i++) load(32'h11 + i);
    sent_q.delete();
    set_empty();
    enable = 1'b1; ready = 1'b1;
    do_cycle();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_data", 32'(data), 0);
    rst = 1'b0;

    // Preloaded 0x11..0x18, full-rate drain.
    clr_track();
    for (int i = 0; i < 30 && got_q.size() < 8; i++) do_cycle();
    chk("burst_count", got_q.size(), 8);
    chk("burst_latency", 32'(first_valid - first_rd), 2);
    if (got_q.size() == 8) begin
      chk("burst_back_to_back", 32'(pop_cyc[7] - pop_cyc[0]), 7);
      for (int i = 0; i < 8; i++) begin
        chk("burst_word", got_q[i], 32'h11 + i);
        chk("burst_last", 32'(last_q[i]), 32'((i == 3) || (i == 7)));
      end
    end

    // Downstream stalled: only two reads may be issued.
    clr_track();
    for (int i = 0; i < 4; i++) load(32'h20 + i);
    set_empty();
    ready = 1'b0;
    repeat (5) do_cycle();
    chk("stall_reads", 32'(rd_cnt), 2);
    chk("stall_hold", 32'(data), 32'h20);
    ready = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) do_cycle();
    chk("stall_drained", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("stall_word", got_q[i], 32'h20 + i);

    // Ready toggling every cycle with 16 random words.
    clr_track();
    sent_q.delete();
    for (int i = 0; i < 16; i++) load(WIDTH'($urandom));
    set_empty();
    for (int i = 0; i < 100 && (got_q.size() < 16 || exp_q.size() > 0); i++) begin
      ready = (i % 2 == 0);
      do_cycle();
    end
    chk("toggle_count", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) chk("toggle_order", got_q[i], sent_q[i]);

    // FIFO reports empty after three reads.
    clr_track();
    ready = 1'b1;
    for (int i = 0; i < 8; i++) load(32'h40 + i);
    set_empty();
    for (int i = 0; i < 20; i++) begin
      if (rd_cnt >= 3) begin
        force_empty = 1'b1;
        set_empty();
      end
      do_cycle();
    end
    chk("empty_reads", 32'(rd_cnt), 3);
    chk("empty_delivered", got_q.size(), 3);
    chk("empty_valid", 32'(valid), 0);
    force_empty = 1'b0;
    src_q.delete();
    set_empty();

    // Reset while one word is held and one is in flight.
    clr_track();
    for (int i = 0; i < 4; i++) load(32'h60 + i);
    set_empty();
    ready = 1'b0;
    repeat (2) do_cycle();
    chk("pre_rst_valid", 32'(valid), 1);
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
    src_q.delete();
    set_empty();
    chk("post_rst_valid", 32'(valid), 0);
    chk("post_rst_last", 32'(last), 0);
    clr_track();
    for (int i = 0; i < 8; i++) load(32'h70 + i);
    set_empty();
    ready = 1'b1;
    for (int i = 0; i < 30 && got_q.size() < 8; i++) do_cycle();
    chk("post_rst_count", got_q.size(), 8);
    for (int i = 0; i < 4 && i < last_q.size(); i++)
      chk("post_rst_last_pos", 32'(last_q[i]), 32'(i == 3));

    // Random enable, ready, empty and data.
    clr_track();
    for (int i = 0; i < 400; i++) begin
      enable      = ($urandom_range(0, 7) != 0);
      ready       = $urandom_range(0, 1) == 1;
      force_empty = ($urandom_range(0, 5) == 0);
      if (src_q.size() < 4 && $urandom_range(0, 1) == 1) load(WIDTH'($urandom));
      set_empty();
      do_cycle();
    end
    enable = 1'b0; ready = 1'b1; force_empty = 1'b0;
    set_empty();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) do_cycle();
    chk("rand_drained", exp_q.size(), 0);
    do_cycle();
    chk("rand_idle_valid", 32'(valid), 0);

`ifdef FIFO_STREAM_READER_STATS_EN
    // Beat counter wraps at 16 bits.
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
    src_q.delete();
    set_empty();
    chk("wc_reset", 32'(word_count), 0);
    enable = 1'b1; ready = 1'b1;
    for (int i = 0; i < 70100 && total_beats < 70000; i++) begin
      if (src_q.size() < 4) load(WIDTH'($urandom));
      if (sent_q.size() > 64) sent_q.delete();
      set_empty();
      do_cycle();
    end
    chk("wc_beats", total_beats, 70000);
    chk("wc_value", 32'(word_count), 32'd4464);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
